// File: rtl/dense_layer_seq.sv
// dense_layer_seq: sequences one fully-connected layer. Takes one activation per
// handshake, steps the weight ROM row address by N_OUT and strobes the MAC lanes.
// It then waits out the MAC latency and offers the result to the next layer.
// Ports: clk, reset_n (async active-low); start/abort/busy control;
// x_valid/x_data/x_ready activation input; rom_addr, mac_clr, mac_en, mac_x to the
// ROM and lanes; out_valid/out_ready/done result handshake; perf_stall_cnt.
// Optional: define DENSE_SEQ_PERF_EN to build the stall counter (else tied to 0).
module dense_layer_seq #(
    parameter int N_IN    = 34,
    parameter int N_OUT   = 15,
    parameter int MAC_LAT = 4,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    input  logic              x_valid,
    input  logic [31:0]       x_data,
    output logic              x_ready,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              mac_clr,
    output logic              mac_en,
    output logic [31:0]       mac_x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              done,
    output logic [15:0]       perf_stall_cnt
);

    localparam int RW = $clog2(N_IN + 1);
    localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    localparam logic [RW-1:0]     LAST_ROW   = RW'(N_IN - 1);
    localparam logic [DW-1:0]     DRAIN_LOAD = DW'(MAC_LAT - 1);
    localparam logic [ADDR_W-1:0] STRIDE     = ADDR_W'(N_OUT);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLEAR = 3'd1;
    localparam logic [2:0] FETCH = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] OUT   = 3'd4;

    logic [2:0]        state;
    logic [2:0]        next_state;
    logic [RW-1:0]     row;
    logic [ADDR_W-1:0] base;
    logic [DW-1:0]     dcnt;
    logic              hs;
    logic              last;

    assign busy      = (state != IDLE);
    assign x_ready   = (state == FETCH);
    assign out_valid = (state == OUT);

    // Accepted activation; abort overrides any handshake in the same cycle.
    assign hs   = (state == FETCH) && x_valid && !abort;
    assign last = (row == LAST_ROW);

    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) next_state = CLEAR;
                CLEAR:   next_state = FETCH;
                FETCH:   if (x_valid && last) next_state = DRAIN;
                DRAIN:   if (dcnt == '0) next_state = OUT;
                OUT:     if (out_ready) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            mac_clr  <= 1'b0;
            mac_en   <= 1'b0;
            done     <= 1'b0;
            rom_addr <= '0;
            mac_x    <= '0;
            row      <= '0;
            base     <= '0;
            dcnt     <= '0;
        end else begin
            state   <= next_state;
            mac_clr <= (state == IDLE) && start && !abort;
            mac_en  <= hs;
            done    <= (state == OUT) && out_ready && !abort;

            if (state == CLEAR) begin
                row  <= '0;
                base <= '0;
            end else if (hs) begin
                mac_x    <= x_data;
                rom_addr <= base;
                base     <= base + STRIDE;
                row      <= row + RW'(1);
            end

            // Loaded on the last handshake so DRAIN spans exactly MAC_LAT cycles.
            if (hs && last)
                dcnt <= DRAIN_LOAD;
            else if (state == DRAIN && dcnt != '0)
                dcnt <= dcnt - DW'(1);
        end
    end

`ifdef DENSE_SEQ_PERF_EN
    logic stall;

    assign stall = ((state == FETCH) && !x_valid) ||
                   ((state == OUT) && !out_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            perf_stall_cnt <= '0;
        else if (state == CLEAR)
            perf_stall_cnt <= '0;
        else if (stall && perf_stall_cnt != 16'hFFFF)
            perf_stall_cnt <= perf_stall_cnt + 16'd1;
    end
`else
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dense_layer_seq.sv
// tb_dense_layer_seq: scoreboard bench for dense_layer_seq.
// Stimulus queues expected MAC commands; a negedge monitor pops and compares.
module tb_dense_layer_seq;

    localparam int N_IN    = 34;
    localparam int N_OUT   = 15;
    localparam int MAC_LAT = 4;
    localparam int ADDR_W  = 32;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              x_valid = 1'b0;
    logic [31:0]       x_data = '0;
    logic              out_ready = 1'b0;
    logic              busy;
    logic              x_ready;
    logic [ADDR_W-1:0] rom_addr;
    logic              mac_clr;
    logic              mac_en;
    logic [31:0]       mac_x;
    logic              out_valid;
    logic              done;
    logic [15:0]       perf_stall_cnt;

    dense_layer_seq #(
        .N_IN(N_IN), .N_OUT(N_OUT), .MAC_LAT(MAC_LAT), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .busy(busy), .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready),
        .rom_addr(rom_addr), .mac_clr(mac_clr), .mac_en(mac_en),
        .mac_x(mac_x), .out_valid(out_valid), .out_ready(out_ready),
        .done(done), .perf_stall_cnt(perf_stall_cnt)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] x;
    } cmd_t;

    cmd_t exp_q[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int clr_cyc = 0;
    int first_mac = 0;
    int last_mac = 0;
    int mac_cnt = 0;
    int done_cnt = 0;
    bit seen_mac = 1'b0;
    int s_cyc = 0;
    int ov_cyc = 0;
    int stall = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b", nm, act, req);
        end
    endtask

    function automatic logic [31:0] exp_perf(input int n);
`ifdef DENSE_SEQ_PERF_EN
        return (n > 65535) ? 32'd65535 : 32'(n);
`else
        return 32'(n - n);
`endif
    endfunction

    // Monitor: every MAC strobe must match the next queued command.
    always @(negedge clk) begin
        cmd_t e;
        if (mac_clr) begin
            clr_cyc  = cyc;
            seen_mac = 1'b0;
            mac_cnt  = 0;
        end
        if (mac_en) begin
            if (!seen_mac) first_mac = cyc;
            seen_mac = 1'b1;
            last_mac = cyc;
            mac_cnt++;
            chk1("sb_has_entry", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rom_addr", rom_addr, e.a);
                chk("mac_x", mac_x, e.x);
            end
        end
        if (done) done_cnt++;
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        s_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: always valid, 1: every other cycle, 2: random gaps.
    task automatic feed(input int mode, input int spur_row,
                        input int abort_row, input bit hold_after);
        int row = 0;
        int budget = 0;
        logic [31:0] d;
        bit v;
        cmd_t e;
        stall = 0;
        while (row < N_IN && budget < 1000) begin
            @(negedge clk);
            budget++;
            case (mode)
                0:       v = 1'b1;
                1:       v = (budget % 2) == 0;
                default: v = $urandom_range(0, 3) != 0;
            endcase
            d = $urandom;
            x_valid = v;
            x_data  = d;
            start   = (row == spur_row);
            abort   = (row == abort_row);
            if (abort) begin
                x_valid = 1'b1;
                break;
            end
            if (x_ready && !v) stall++;
            if (x_ready && v) begin
                e.a = 32'(row * N_OUT);
                e.x = d;
                exp_q.push_back(e);
                row++;
            end
        end
        chk1("feed_in_budget", budget < 1000, 1'b1);
        if (!abort) begin
            @(negedge clk);
            start   = 1'b0;
            x_valid = hold_after;
            chk1("x_ready_after_last", x_ready, 1'b0);
        end
    endtask

    // timing: 0 none, 1 clear cycle only, 2 full back-to-back schedule.
    task automatic finish(input int bp, input int timing);
        bit found = 1'b0;
        logic [15:0] p;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            x_valid = 1'b0;
            if (out_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk1("out_valid_seen", found, 1'b1);
        if (!found) return;
        ov_cyc = cyc;
        for (int k = 0; k < bp; k++) begin
            @(negedge clk);
            chk1("out_valid_held", out_valid, 1'b1);
            chk1("no_early_done", done, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk1("done_pulse", done, 1'b1);
        chk1("busy_after_done", busy, 1'b0);
        chk1("out_valid_after", out_valid, 1'b0);
        chk("perf_at_done", 32'(perf_stall_cnt), exp_perf(stall + bp));
        chk("mac_count", mac_cnt, N_IN);
        chk("sb_empty", exp_q.size(), 0);
        if (timing >= 1) chk("clr_cycle", clr_cyc - s_cyc, 1);
        if (timing >= 2) begin
            chk("first_mac_cycle", first_mac - s_cyc, 3);
            chk("last_mac_cycle", last_mac - s_cyc, 36);
            chk("out_valid_cycle", ov_cyc - s_cyc, 36 + MAC_LAT);
            chk("done_cycle", cyc - s_cyc, 37 + MAC_LAT);
        end
        p = perf_stall_cnt;
        @(negedge clk);
        chk1("done_one_cycle", done, 1'b0);
        chk("perf_held_idle", 32'(perf_stall_cnt), exp_perf(stall + bp));
        chk("perf_prev", 32'(p), exp_perf(stall + bp));
    endtask

    task automatic chk_zero(input string nm);
        chk1({nm, "_busy"}, busy, 1'b0);
        chk1({nm, "_x_ready"}, x_ready, 1'b0);
        chk1({nm, "_mac_clr"}, mac_clr, 1'b0);
        chk1({nm, "_mac_en"}, mac_en, 1'b0);
        chk1({nm, "_out_valid"}, out_valid, 1'b0);
        chk1({nm, "_done"}, done, 1'b0);
        chk({nm, "_rom_addr"}, rom_addr, 32'd0);
        chk({nm, "_mac_x"}, mac_x, 32'd0);
        chk({nm, "_perf"}, 32'(perf_stall_cnt), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);
        chk_zero("post_reset");

        // back-to-back, x_valid held high past the last row
        do_start();
        feed(0, -1, -1, 1'b1);
        finish(0, 2);

        // gapped input
        do_start();
        feed(1, -1, -1, 1'b0);
        finish(0, 1);

        // output backpressure
        do_start();
        feed(0, -1, -1, 1'b0);
        finish(10, 1);

        // start at row 5 must be ignored
        do_start();
        feed(0, 5, -1, 1'b0);
        finish(0, 2);

        // abort at row 20 with x_valid high
        d0 = done_cnt;
        do_start();
        feed(0, -1, 20, 1'b0);
        @(negedge clk);
        abort   = 1'b0;
        x_valid = 1'b0;
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_x_ready", x_ready, 1'b0);
        chk1("abort_mac_en", mac_en, 1'b0);
        chk1("abort_out_valid", out_valid, 1'b0);
        repeat (3) @(negedge clk);
        chk("abort_no_done", done_cnt, d0);
        chk("abort_rows", mac_cnt, 20);
        chk("abort_sb_empty", exp_q.size(), 0);
        do_start();
        feed(2, -1, -1, 1'b0);
        finish(2, 1);

        // reset pulsed mid-DRAIN, between clock edges
        do_start();
        feed(0, -1, -1, 1'b0);
        #2 reset_n = 1'b0;
        #1 chk_zero("mid_drain_reset");
        @(negedge clk);
        reset_n = 1'b1;
        chk("reset_sb_empty", exp_q.size(), 0);
        do_start();
        feed(2, -1, -1, 1'b0);
        finish(5, 1);

        for (int r = 0; r < 3; r++) begin
            do_start();
            feed(2, -1, -1, 1'b0);
            finish(int'($urandom_range(0, 4)), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dense_layer_seq.md
Name: dense_layer_seq

Overview:
- Sequences one fully-connected layer.
- Accepts input activations one per handshake and drives the row address of the stride-N_OUT weight ROM (N_OUT packed 32-bit float weights per row).
- Issues one broadcast MAC command per row to an N_OUT-lane floating-point MAC array, waits out the MAC pipeline, then presents a result-valid handshake to the next layer.
- Sits between the activation source (previous layer or input buffer) and the weight ROM + MAC lanes.

Parameters:
- N_IN, 34: input activations per inference (ROM rows).
- N_OUT, 15: weights per ROM row (MAC lanes); also the address stride.
- MAC_LAT, 4: MAC array latency in cycles, mac_en to accumulator updated; minimum 1.
- ADDR_W, 32: width of rom_addr.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous active-low reset.
- start  in  1  begin inference; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE.
- busy  out  1  high in any state other than IDLE.
- x_valid  in  1  input activation valid.
- x_data  in  32  input activation (IEEE-754 single).
- x_ready  out  1  block accepts x_data.
- rom_addr  out  ADDR_W  weight ROM row base address, equal to row*N_OUT.
- mac_clr  out  1  one-cycle accumulator clear.
- mac_en  out  1  one-cycle MAC strobe; lanes use rom_addr and mac_x.
- mac_x  out  32  activation broadcast to all lanes.
- out_valid  out  1  accumulators hold the final layer result.
- out_ready  in  1  downstream consumed the result.
- done  out  1  one-cycle pulse after out handshake.
- perf_stall_cnt  out  16  stall-cycle count (see Optional Feature).

Behaviour:
- Reset (async, Reset_n=0):
  - state=IDLE.
  - busy, x_ready, mac_clr, mac_en, out_valid, done = 0.
  - rom_addr=0, mac_x=0, perf_stall_cnt=0, row counter=0, base-address register=0.
- All outputs are registered, except x_ready, busy and out_valid, which are decoded from the state register only. Nothing is combinational from inputs.
- IDLE: start=1 -> CLEAR. start in any other state is ignored.
- CLEAR: one cycle.
  - mac_clr=1.
  - Row counter and base-address register reset to 0.
  - Next state is FETCH.
- FETCH: x_ready=1. On the edge where x_valid&x_ready:
  - mac_x<=x_data, rom_addr<=base, mac_en<=1 for the next cycle.
  - base<=base+N_OUT, implemented with an adder, no multiplier.
  - row<=row+1.
  - Throughput is one row per cycle.
- FETCH with no handshake: mac_en<=0 and rom_addr holds its value.
- Last row: the handshake with row==N_IN-1 -> DRAIN. x_ready is low from the following cycle.
- Address range: rom_addr never exceeds (N_IN-1)*N_OUT. The lanes read rom_addr..rom_addr+N_OUT-1, so the top address is N_IN*N_OUT-1 (509 at defaults).
- DRAIN: a down-counter loaded with MAC_LAT-1 on entry. When it reaches 0 -> OUT. DRAIN lasts exactly MAC_LAT cycles.
- OUT:
  - out_valid=1, held until out_ready=1 at a clock edge.
  - Then -> IDLE, with done=1 in the first IDLE cycle.
  - out_ready outside OUT is ignored.
- abort=1 in any state:
  - Next state is IDLE; mac_en<=0.
  - No done pulse; accumulators are not cleared.
  - abort has priority over start and over every handshake in the same cycle.
- Reset mid-operation: immediate return to reset values. The inference is discarded.
- Simultaneous x_valid and last-row transition: the handshake is accepted, then DRAIN. No extra row is consumed.

Optional Feature:
- Macro: DENSE_SEQ_PERF_EN.
- Defined:
  - perf_stall_cnt counts cycles in FETCH with x_valid=0, plus cycles in OUT with out_ready=0.
  - It clears in CLEAR and saturates at 16'hFFFF.
  - It holds its value in IDLE.
- Undefined: perf_stall_cnt is tied to 0 and no counter logic is built.

Test Plan:
- Back-to-back inference at defaults:
  - start at cycle 0 -> mac_clr at cycle 1.
  - x_valid held high, x_data=row index -> mac_en high cycles 3..36.
  - rom_addr=0,15,30,...,495 on those cycles; mac_x matches.
  - out_valid at cycle 40; out_ready=1 -> done at cycle 41, busy low.
- Gapped input: x_valid low every other cycle -> mac_en only after accepted handshakes; exactly 34 mac_en pulses; addresses in order; x_ready drops after the 34th.
- Output backpressure: out_ready low for 10 cycles in OUT -> out_valid held; no done; state stable; with PERF_EN, perf_stall_cnt=10 at done.
- start during FETCH at row 5 -> ignored; rom_addr continues 75, 90, ...
- abort at row 20, asserted together with x_valid -> no mac_en next cycle; IDLE; busy=0; no done. A new start then re-clears and rom_addr restarts at 0.
- Reset_n pulsed low mid-DRAIN (asynchronously, between edges) -> all outputs 0 immediately. After release, start produces a normal full run.
